// File: rtl/lv_wdg_scan.sv
// lv_wdg_scan: background register CRC-8 scanner plus SPI-inactivity watchdog.
// Reads one address at a time from the controller, flags the first CRC mismatch and times SPI silence.
module lv_wdg_scan #(
    parameter int                REG_AW          = 7,
    parameter int                REG_DW          = 8,
    parameter int                REG_CRC_W       = 8,
    parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
    parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h3F,
    parameter int                SCAN_GAP_CYC    = 16,
    parameter int                ACK_TMO_CYC     = 32,
    parameter int                WDG_TMO_CYC     = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scan_en,
    input  logic                 i_err_clr,
    input  logic                 i_spi_rst_wdg,
    output logic                 o_wdg_scan_rac_rd_req,
    output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
    input  logic                 i_rac_wdg_scan_ack,
    input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
    input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
    output logic                 o_scan_crc_err,
    output logic                 o_scan_err_flag,
    output logic [REG_AW-1:0]    o_scan_err_addr,
    output logic                 o_scan_ack_tmo,
    output logic                 o_wdg_tmo,
    output logic                 o_scan_round_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;

    localparam int GAP_W = (SCAN_GAP_CYC > 1) ? $clog2(SCAN_GAP_CYC) : 1;
    localparam int TMO_W = $clog2(ACK_TMO_CYC);
    localparam int WDG_W = $clog2(WDG_TMO_CYC);

    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(SCAN_GAP_CYC - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(ACK_TMO_CYC - 1);
    localparam logic [WDG_W-1:0]     WDG_LAST = WDG_W'(WDG_TMO_CYC - 1);
    localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(8'h07);

    // Bit-serial CRC, MSB first, init 0, over the data byte only.
    function automatic logic [REG_CRC_W-1:0] f_crc(input logic [REG_DW-1:0] d);
        logic [REG_CRC_W-1:0] c;
        c = '0;
        for (int i = REG_DW - 1; i >= 0; i--) begin
            if (c[REG_CRC_W-1] ^ d[i]) c = (c << 1) ^ CRC_POLY;
            else                       c = c << 1;
        end
        return c;
    endfunction

    logic [1:0]        r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [WDG_W-1:0]  r_wdg_cnt;
    logic              r_rd_req;
    logic [REG_AW-1:0] r_addr;
    logic              r_crc_err;
    logic              r_err_flag;
    logic [REG_AW-1:0] r_err_addr;
    logic              r_ack_tmo;
    logic              r_wdg_tmo;
    logic              r_round_done;

    logic w_in_req, w_ack, w_tmo, w_done, w_crc_bad, w_wrap, w_wdg_hit;

    // Acks outside REQ are dropped here, so nothing downstream sees them.
    assign w_in_req  = (r_state == ST_REQ);
    assign w_ack     = w_in_req & i_rac_wdg_scan_ack;
    assign w_tmo     = w_in_req & ~i_rac_wdg_scan_ack & (r_tmo_cnt == TMO_LAST);
    assign w_done    = w_ack | w_tmo;
    assign w_crc_bad = w_ack & (f_crc(i_rac_wdg_scan_data) != i_rac_wdg_scan_crc);
    assign w_wrap    = (r_addr == SCAN_END_ADDR);
    assign w_wdg_hit = ~i_spi_rst_wdg & (r_wdg_cnt == WDG_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_gap_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_rd_req     <= 1'b0;
            r_addr       <= SCAN_START_ADDR;
            r_round_done <= 1'b0;
        end else begin
            r_round_done <= w_done & w_wrap;
            case (r_state)
                ST_IDLE: begin
                    if (i_scan_en) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (!i_scan_en) begin
                        r_state <= ST_IDLE;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_state   <= ST_REQ;
                        r_rd_req  <= 1'b1;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    // An outstanding read always completes, even if scan_en fell.
                    if (w_done) begin
                        r_rd_req  <= 1'b0;
                        r_gap_cnt <= '0;
                        r_state   <= i_scan_en ? ST_GAP : ST_IDLE;
                        r_addr    <= w_wrap ? SCAN_START_ADDR : r_addr + 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_rd_req <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a set condition in the same cycle beats i_err_clr.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc_err  <= 1'b0;
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
            r_ack_tmo  <= 1'b0;
            r_wdg_tmo  <= 1'b0;
            r_wdg_cnt  <= '0;
        end else begin
            r_crc_err <= w_crc_bad;
            if (w_crc_bad) begin
                r_err_flag <= 1'b1;
                if (!r_err_flag || i_err_clr) r_err_addr <= r_addr;
            end else if (i_err_clr) begin
                r_err_flag <= 1'b0;
                r_err_addr <= '0;
            end

            if (w_tmo)          r_ack_tmo <= 1'b1;
            else if (i_err_clr) r_ack_tmo <= 1'b0;

            if (i_spi_rst_wdg)                          r_wdg_cnt <= '0;
            else if (i_scan_en && r_wdg_cnt != WDG_LAST) r_wdg_cnt <= r_wdg_cnt + 1'b1;

            if (w_wdg_hit)      r_wdg_tmo <= 1'b1;
            else if (i_err_clr) r_wdg_tmo <= 1'b0;
        end
    end

    assign o_wdg_scan_rac_rd_req = r_rd_req;
    assign o_wdg_scan_rac_addr   = r_addr;
    assign o_scan_crc_err        = r_crc_err;
    assign o_scan_err_flag       = r_err_flag;
    assign o_scan_err_addr       = r_err_addr;
    assign o_scan_ack_tmo        = r_ack_tmo;
    assign o_wdg_tmo             = r_wdg_tmo;
    assign o_scan_round_done     = r_round_done;

endmodule

// File: tb/tb_lv_wdg_scan.sv
// Bench for lv_wdg_scan: instance A (window 0x00-0x3F, WDG 8) for scan/watchdog, instance B (0x3E-0x3F) for wrap.
module tb_lv_wdg_scan;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic       a_en, a_clr, a_kick, a_ack;
    logic [7:0] a_data, a_crc;
    logic       a_req, a_crc_err, a_err_flag, a_ack_tmo, a_wdg_tmo, a_rdone;
    logic [6:0] a_addr, a_err_addr;

    logic       b_en, b_clr, b_kick, b_ack;
    logic [7:0] b_data, b_crc;
    logic       b_req, b_crc_err, b_err_flag, b_ack_tmo, b_wdg_tmo, b_rdone;
    logic [6:0] b_addr, b_err_addr;

    logic [6:0] a_q[$];
    logic [6:0] b_q[$];

    lv_wdg_scan #(.WDG_TMO_CYC(8)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(a_en), .i_err_clr(a_clr),
        .i_spi_rst_wdg(a_kick), .o_wdg_scan_rac_rd_req(a_req), .o_wdg_scan_rac_addr(a_addr),
        .i_rac_wdg_scan_ack(a_ack), .i_rac_wdg_scan_data(a_data), .i_rac_wdg_scan_crc(a_crc),
        .o_scan_crc_err(a_crc_err), .o_scan_err_flag(a_err_flag), .o_scan_err_addr(a_err_addr),
        .o_scan_ack_tmo(a_ack_tmo), .o_wdg_tmo(a_wdg_tmo), .o_scan_round_done(a_rdone));

    lv_wdg_scan #(.SCAN_START_ADDR(7'h3E), .SCAN_END_ADDR(7'h3F), .SCAN_GAP_CYC(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(b_en), .i_err_clr(b_clr),
        .i_spi_rst_wdg(b_kick), .o_wdg_scan_rac_rd_req(b_req), .o_wdg_scan_rac_addr(b_addr),
        .i_rac_wdg_scan_ack(b_ack), .i_rac_wdg_scan_data(b_data), .i_rac_wdg_scan_crc(b_crc),
        .o_scan_crc_err(b_crc_err), .o_scan_err_flag(b_err_flag), .o_scan_err_addr(b_err_addr),
        .o_scan_ack_tmo(b_ack_tmo), .o_wdg_tmo(b_wdg_tmo), .o_scan_round_done(b_rdone));

    task automatic apply_reset();
        rst_n = 1'b0;
        a_en = 0; a_clr = 0; a_kick = 0; a_ack = 0; a_data = 0; a_crc = 0;
        b_en = 0; b_clr = 0; b_kick = 0; b_ack = 0; b_data = 0; b_crc = 0;
        a_q.delete(); a_q.push_back(7'h00);
        b_q.delete(); b_q.push_back(7'h3E);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_req_a(output bit ok);
        int n = 0;
        while (!a_req && n < 200) begin @(negedge clk); n++; end
        ok = a_req;
        if (!ok) begin n_cmp++; n_err++; $display("FAIL req_wait_a: got no rd_req want rd_req within 200 cycles"); end
    endtask

    // One read on A: scoreboard supplies the expected address, ack comes lat cycles after req.
    task automatic a_read(input int lat, input logic [7:0] d, input logic [7:0] c, input bit exp_err);
        bit ok;
        logic [6:0] exp, nxt;
        wait_req_a(ok);
        if (!ok) return;
        n_cmp++;
        if (a_q.size() == 0) begin n_err++; $display("FAIL addr_q: got empty queue want entry"); exp = a_addr; end
        else begin
            exp = a_q.pop_front();
            if (a_addr !== exp) begin n_err++; $display("FAIL req_addr: got %0h want %0h", a_addr, exp); end
        end
        repeat (lat) @(negedge clk);
        n_cmp++;
        if (a_req !== 1'b1) begin n_err++; $display("FAIL req_hold: got %0b want 1", a_req); end
        a_ack = 1; a_data = d; a_crc = c;
        @(negedge clk);
        a_ack = 0; a_data = 0; a_crc = 0;
        nxt = (exp == 7'h3F) ? 7'h00 : exp + 7'd1;
        a_q.push_back(nxt);
        n_cmp++;
        if (a_req !== 1'b0) begin n_err++; $display("FAIL req_drop: got %0b want 0", a_req); end
        n_cmp++;
        if (a_crc_err !== exp_err) begin n_err++; $display("FAIL crc_err_pulse: got %0b want %0b", a_crc_err, exp_err); end
        n_cmp++;
        if (a_addr !== nxt) begin n_err++; $display("FAIL addr_adv: got %0h want %0h", a_addr, nxt); end
        @(negedge clk);
        n_cmp++;
        if (a_crc_err !== 1'b0) begin n_err++; $display("FAIL crc_err_width: got %0b want 0", a_crc_err); end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (a_req !== 0)        begin n_err++; $display("FAIL rst_req: got %0b want 0", a_req); end
        n_cmp++; if (a_addr !== 7'h00)   begin n_err++; $display("FAIL rst_addr_a: got %0h want 0", a_addr); end
        n_cmp++; if (b_addr !== 7'h3E)   begin n_err++; $display("FAIL rst_addr_b: got %0h want 3e", b_addr); end
        n_cmp++; if ({a_crc_err, a_err_flag, a_ack_tmo, a_wdg_tmo, a_rdone} !== 5'b0)
            begin n_err++; $display("FAIL rst_flags: got %05b want 00000", {a_crc_err, a_err_flag, a_ack_tmo, a_wdg_tmo, a_rdone}); end
        n_cmp++; if (a_err_addr !== 7'h00) begin n_err++; $display("FAIL rst_err_addr: got %0h want 0", a_err_addr); end
    endtask

    task automatic test_nominal();
        int n;
        apply_reset();
        a_en = 1;
        a_read(3, 8'h01, 8'h07, 1'b0);
        n = 1;
        while (!a_req && n < 100) begin @(negedge clk); n++; end
        n_cmp++; if (n !== 16) begin n_err++; $display("FAIL gap_spacing: got %0d want 16", n); end
        a_read(1, 8'hFF, 8'hF3, 1'b0);
        n_cmp++; if (a_err_flag !== 0 || a_ack_tmo !== 0)
            begin n_err++; $display("FAIL nominal_flags: got %0b%0b want 00", a_err_flag, a_ack_tmo); end
        a_en = 0;
    endtask

    task automatic test_crc_mismatch();
        apply_reset();
        a_en = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                a_read(1, 8'h01, 8'h06, 1'b1);
                n_cmp++; if (a_err_flag !== 1) begin n_err++; $display("FAIL err_flag_set: got %0b want 1", a_err_flag); end
                n_cmp++; if (a_err_addr !== 7'h05) begin n_err++; $display("FAIL err_addr_first: got %0h want 5", a_err_addr); end
            end else if (i == 9) begin
                a_read(2, 8'h80, 8'h00, 1'b1);
                n_cmp++; if (a_err_addr !== 7'h05) begin n_err++; $display("FAIL err_addr_keep: got %0h want 5", a_err_addr); end
            end else begin
                a_read(1, 8'h00, 8'h00, 1'b0);
            end
        end
        a_clr = 1; @(negedge clk); a_clr = 0;
        n_cmp++; if (a_err_flag !== 0) begin n_err++; $display("FAIL err_flag_clr: got %0b want 0", a_err_flag); end
        n_cmp++; if (a_err_addr !== 7'h00) begin n_err++; $display("FAIL err_addr_clr: got %0h want 0", a_err_addr); end
        a_en = 0;
    endtask

    task automatic test_ack_tmo();
        bit ok;
        int n;
        logic [6:0] exp;
        apply_reset();
        a_en = 1;
        wait_req_a(ok);
        if (ok) begin
            exp = a_q.pop_front();
            n_cmp++; if (a_addr !== exp) begin n_err++; $display("FAIL tmo_addr: got %0h want %0h", a_addr, exp); end
            n = 0;
            while (a_req && n < 100) begin n++; @(negedge clk); end
            a_q.push_back(exp + 7'd1);
            n_cmp++; if (n !== 32) begin n_err++; $display("FAIL tmo_req_len: got %0d want 32", n); end
            n_cmp++; if (a_ack_tmo !== 1) begin n_err++; $display("FAIL ack_tmo_set: got %0b want 1", a_ack_tmo); end
            n_cmp++; if (a_crc_err !== 0) begin n_err++; $display("FAIL tmo_no_crc: got %0b want 0", a_crc_err); end
        end
        a_read(1, 8'h00, 8'h00, 1'b0);
        a_clr = 1; @(negedge clk); a_clr = 0;
        n_cmp++; if (a_ack_tmo !== 0) begin n_err++; $display("FAIL ack_tmo_clr: got %0b want 0", a_ack_tmo); end
        a_en = 0;
    endtask

    task automatic test_wrap();
        int n;
        logic [6:0] exp;
        apply_reset();
        b_en = 1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!b_req && n < 100) begin @(negedge clk); n++; end
            n_cmp++;
            if (!b_req) begin n_err++; $display("FAIL wrap_req_wait: got no rd_req want rd_req"); break; end
            exp = b_q.pop_front();
            if (b_addr !== exp) begin n_err++; $display("FAIL wrap_addr: got %0h want %0h", b_addr, exp); end
            b_ack = 1; b_data = 8'hFF; b_crc = 8'hF3;
            @(negedge clk);
            b_ack = 0; b_data = 0; b_crc = 0;
            b_q.push_back((exp == 7'h3F) ? 7'h3E : 7'h3F);
            n_cmp++; if (b_rdone !== (exp == 7'h3F))
                begin n_err++; $display("FAIL round_done: got %0b want %0b", b_rdone, (exp == 7'h3F)); end
            @(negedge clk);
            n_cmp++; if (b_rdone !== 0) begin n_err++; $display("FAIL round_done_width: got %0b want 0", b_rdone); end
        end
        n_cmp++; if (b_err_flag !== 0) begin n_err++; $display("FAIL wrap_err: got %0b want 0", b_err_flag); end
        b_en = 0;
    endtask

    task automatic test_watchdog();
        int n;
        apply_reset();
        a_en = 1;
        n = 0;
        while (!a_wdg_tmo && n < 50) begin @(negedge clk); n++; end
        n_cmp++; if (n !== 8) begin n_err++; $display("FAIL wdg_plain: got %0d want 8", n); end

        apply_reset();
        a_en = 1;
        repeat (6) @(negedge clk);
        a_kick = 1; @(negedge clk); a_kick = 0;
        n = 7;
        while (!a_wdg_tmo && n < 80) begin @(negedge clk); n++; end
        n_cmp++; if (n !== 15) begin n_err++; $display("FAIL wdg_kick: got %0d want 15", n); end

        a_clr = 1; @(negedge clk); a_clr = 0;
        n_cmp++; if (a_wdg_tmo !== 1) begin n_err++; $display("FAIL wdg_clr_vs_set: got %0b want 1", a_wdg_tmo); end
        a_kick = 1; @(negedge clk); a_kick = 0;
        n_cmp++; if (a_wdg_tmo !== 1) begin n_err++; $display("FAIL wdg_kick_keeps: got %0b want 1", a_wdg_tmo); end
        a_clr = 1; @(negedge clk); a_clr = 0;
        n_cmp++; if (a_wdg_tmo !== 0) begin n_err++; $display("FAIL wdg_clr: got %0b want 0", a_wdg_tmo); end

        apply_reset();
        a_en = 1;
        repeat (4) @(negedge clk);
        a_en = 0;
        repeat (20) @(negedge clk);
        n_cmp++; if (a_wdg_tmo !== 0) begin n_err++; $display("FAIL wdg_hold_tmo: got %0b want 0", a_wdg_tmo); end
        a_en = 1;
        n = 0;
        while (!a_wdg_tmo && n < 50) begin @(negedge clk); n++; end
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL wdg_hold_resume: got %0d want 4", n); end
        a_en = 0;
    endtask

    task automatic test_en_drop();
        bit ok;
        int hits;
        apply_reset();
        a_en = 1;
        wait_req_a(ok);
        if (!ok) begin a_en = 0; return; end
        a_en = 0;
        repeat (5) @(negedge clk);
        n_cmp++; if (a_req !== 1) begin n_err++; $display("FAIL drop_req_kept: got %0b want 1", a_req); end
        a_ack = 1; @(negedge clk); a_ack = 0;
        n_cmp++; if (a_req !== 0) begin n_err++; $display("FAIL drop_req_fall: got %0b want 0", a_req); end
        n_cmp++; if (a_addr !== 7'h01) begin n_err++; $display("FAIL drop_addr: got %0h want 1", a_addr); end
        hits = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (a_req) hits++; end
        n_cmp++; if (hits !== 0) begin n_err++; $display("FAIL drop_idle: got %0d req cycles want 0", hits); end
        a_ack = 1; a_data = 8'h01; a_crc = 8'h06; @(negedge clk);
        a_ack = 0; a_data = 0; a_crc = 0;
        n_cmp++; if (a_crc_err !== 0 || a_err_flag !== 0)
            begin n_err++; $display("FAIL stray_ack: got %0b%0b want 00", a_crc_err, a_err_flag); end
    endtask

    task automatic test_async_reset();
        bit ok;
        apply_reset();
        a_en = 1;
        a_read(1, 8'h00, 8'h00, 1'b0);
        wait_req_a(ok);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_req !== 0) begin n_err++; $display("FAIL arst_req: got %0b want 0", a_req); end
        n_cmp++; if (a_addr !== 7'h00) begin n_err++; $display("FAIL arst_addr: got %0h want 0", a_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        a_q.delete(); a_q.push_back(7'h00);
        a_read(1, 8'h00, 8'h00, 1'b0);
        a_en = 0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_crc_mismatch();
        test_ack_tmo();
        test_wrap();
        test_watchdog();
        test_en_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish want finish within 2ms");
        $fatal(1, "timeout");
    end

endmodule
